// File: rtl/jk_cmd_sequencer.sv
// jk_cmd_sequencer
// Command sequencer that drives the J/K inputs of the T-to-JK flip-flop stage.
// HOLD/RESET/SET/TOGGLE commands arrive over a valid/ready handshake. They are
// buffered in a DEPTH-entry FIFO. Each command is then replayed as registered
// j/k for cmd_len+1 cycles. A golden model of Q (exp_q) tracks the flip-flop
// cycle-for-cycle.
// Optional build macro: JK_SEQ_CHECK_EN
//   When defined, q_in is compared against exp_q on every non-reset cycle.
//   Any mismatch sets the sticky err flag.
//   When undefined, err is tied low and q_in is ignored.
module jk_cmd_sequencer #(
    parameter int DEPTH = 4,
    parameter int LEN_W = 4
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     cmd_valid,
    input  logic [1:0]               cmd_op,
    input  logic [LEN_W-1:0]         cmd_len,
    output logic                     cmd_ready,
    output logic                     j,
    output logic                     k,
    input  logic                     q_in,
    output logic                     exp_q,
    output logic                     busy,
    output logic                     done,
    output logic [$clog2(DEPTH):0]   level,
    output logic                     err
);

    localparam int AW = $clog2(DEPTH);
    localparam int EW = 2 + LEN_W;
    localparam logic [AW:0] LEVEL_FULL = (AW+1)'(DEPTH);

    typedef enum logic {
        IDLE  = 1'b0,
        DRIVE = 1'b1
    } state_t;

    // FIFO storage: {op, len}; only the pointers are reset, stale contents are never read
    logic [EW-1:0] fifo_mem [DEPTH];

    logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [AW:0]      level_q, level_d;
    state_t           state_q, state_d;
    logic [LEN_W-1:0] cnt_q, cnt_d;
    logic             j_q, j_d;
    logic             k_q, k_d;
    logic             exp_q_q, exp_q_d;

    logic             push;
    logic             pop;
    logic [EW-1:0]    head_entry;
    logic [1:0]       head_op;
    logic [LEN_W-1:0] head_len;

    // Ready depends only on the registered level, so a full FIFO refuses even on a popping cycle
    assign cmd_ready  = (level_q != LEVEL_FULL);
    assign push       = cmd_valid & cmd_ready;
    assign head_entry = fifo_mem[rd_ptr_q];
    assign head_op    = head_entry[EW-1 -: 2];
    assign head_len   = head_entry[LEN_W-1:0];

    assign j      = j_q;
    assign k      = k_q;
    assign exp_q  = exp_q_q;
    assign level  = level_q;
    assign busy   = (state_q == DRIVE);
    assign done   = (state_q == DRIVE) && (cnt_q == '0);

    // FIFO write port: accepted commands land at the write pointer
    always_ff @(posedge clk) begin
        if (!reset && push) begin
            fifo_mem[wr_ptr_q] <= {cmd_op, cmd_len};
        end
    end

    // Next-state / next-drive logic: pop on idle or at the end of a command (no idle gap)
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        j_d     = j_q;
        k_d     = k_q;
        pop     = 1'b0;
        case (state_q)
            IDLE: begin
                j_d = 1'b0;
                k_d = 1'b0;
                if (level_q != '0) begin
                    pop     = 1'b1;
                    j_d     = head_op[1];
                    k_d     = head_op[0];
                    cnt_d   = head_len;
                    state_d = DRIVE;
                end
            end
            DRIVE: begin
                if (cnt_q != '0) begin
                    cnt_d = cnt_q - LEN_W'(1);
                end else if (level_q != '0) begin
                    pop   = 1'b1;
                    j_d   = head_op[1];
                    k_d   = head_op[0];
                    cnt_d = head_len;
                end else begin
                    j_d     = 1'b0;
                    k_d     = 1'b0;
                    state_d = IDLE;
                end
            end
            default: begin
                j_d     = 1'b0;
                k_d     = 1'b0;
                state_d = IDLE;
            end
        endcase
    end

    // Pointer and occupancy bookkeeping; pointers wrap naturally because DEPTH is a power of two
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        level_d  = level_q;
        if (push) begin
            wr_ptr_d = wr_ptr_q + AW'(1);
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + AW'(1);
        end
        case ({push, pop})
            2'b10:   level_d = level_q + (AW+1)'(1);
            2'b01:   level_d = level_q - (AW+1)'(1);
            default: level_d = level_q;
        endcase
    end

    // Golden Q: same JK behaviour as the flip-flop, applied to the j/k currently being driven
    always_comb begin
        exp_q_d = exp_q_q;
        case ({j_q, k_q})
            2'b00:   exp_q_d = exp_q_q;
            2'b01:   exp_q_d = 1'b0;
            2'b10:   exp_q_d = 1'b1;
            default: exp_q_d = ~exp_q_q;
        endcase
    end

    // State registers; reset discards the in-flight command and everything queued
    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            level_q  <= '0;
            state_q  <= IDLE;
            cnt_q    <= '0;
            j_q      <= 1'b0;
            k_q      <= 1'b0;
            exp_q_q  <= 1'b0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            level_q  <= level_d;
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            j_q      <= j_d;
            k_q      <= k_d;
            exp_q_q  <= exp_q_d;
        end
    end

`ifdef JK_SEQ_CHECK_EN
    logic err_q, err_d;

    // Sticky mismatch flag: any cycle where the real Q disagrees with the prediction
    always_comb begin
        err_d = err_q | (q_in != exp_q_q);
    end

    // Error flag register, cleared only by reset
    always_ff @(posedge clk) begin
        if (reset) begin
            err_q <= 1'b0;
        end else begin
            err_q <= err_d;
        end
    end

    assign err = err_q;
`else
    // Checking disabled: q_in is intentionally unused
    logic unused_q_in;
    assign unused_q_in = q_in;
    assign err         = 1'b0;
`endif

endmodule

// File: tb/tb_jk_cmd_sequencer.sv
// Directed testbench for jk_cmd_sequencer with a small JK flip-flop model closing the q_in loop.
module tb_jk_cmd_sequencer;

    localparam int DEPTH = 4;
    localparam int LEN_W = 4;

    logic             clk = 1'b0;
    logic             reset = 1'b1;
    logic             cmd_valid = 1'b0;
    logic [1:0]       cmd_op = 2'b00;
    logic [LEN_W-1:0] cmd_len = '0;
    logic             cmd_ready;
    logic             j;
    logic             k;
    logic             q_in;
    logic             exp_q;
    logic             busy;
    logic             done;
    logic [2:0]       level;
    logic             err;

    logic q_model = 1'b0;
    logic inj = 1'b0;
    int   total = 0;
    int   bad = 0;

    jk_cmd_sequencer #(.DEPTH(DEPTH), .LEN_W(LEN_W)) dut (
        .clk       (clk),
        .reset     (reset),
        .cmd_valid (cmd_valid),
        .cmd_op    (cmd_op),
        .cmd_len   (cmd_len),
        .cmd_ready (cmd_ready),
        .j         (j),
        .k         (k),
        .q_in      (q_in),
        .exp_q     (exp_q),
        .busy      (busy),
        .done      (done),
        .level     (level),
        .err       (err)
    );

    always #5 clk = ~clk;

    // Downstream JK flip-flop stand-in sharing the reset
    always @(posedge clk) begin
        if (reset) q_model <= 1'b0;
        else begin
            case ({j, k})
                2'b00:   q_model <= q_model;
                2'b01:   q_model <= 1'b0;
                2'b10:   q_model <= 1'b1;
                default: q_model <= ~q_model;
            endcase
        end
    end
    assign q_in = q_model ^ inj;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        cmd_valid = 1'b1; cmd_op = 2'b10; cmd_len = 4'd0;
        step(); step();
        total++;
        if ({j, k, exp_q, busy, done, err, cmd_ready} !== 7'b0000001) begin
            bad++; $display("FAIL reset_outputs got=%b want=%b", {j, k, exp_q, busy, done, err, cmd_ready}, 7'b0000001);
        end
        total++;
        if (level !== 3'd0) begin bad++; $display("FAIL reset_level got=%0d want=0", level); end
        cmd_valid = 1'b0; reset = 1'b0;
        step(); step();
        total++;
        if ({busy, j, k} !== 3'b000 || level !== 3'd0) begin
            bad++; $display("FAIL reset_discard got busy/jk=%b level=%0d want 000 level=0", {busy, j, k}, level);
        end
        $display("test_reset: checked reset state and discarded push");
    endtask

    task automatic test_back_to_back();
        logic [1:0] e_jk [4];
        logic       e_done [4];
        logic       e_q [4];
        logic [2:0] e_lvl [4];
        e_jk = '{2'b10, 2'b01, 2'b01, 2'b01};
        e_done = '{1'b1, 1'b0, 1'b0, 1'b1};
        e_q = '{1'b0, 1'b1, 1'b0, 1'b0};
        e_lvl = '{3'd1, 3'd0, 3'd0, 3'd0};
        cmd_valid = 1'b1; cmd_op = 2'b10; cmd_len = 4'd0;
        step();
        total++;
        if (level !== 3'd1 || busy !== 1'b0) begin
            bad++; $display("FAIL b2b_accept got level=%0d busy=%b want level=1 busy=0", level, busy);
        end
        cmd_op = 2'b01; cmd_len = 4'd2;
        step();
        cmd_valid = 1'b0;
        for (int i = 0; i < 4; i++) begin
            if (i > 0) step();
            total++;
            if ({j, k} !== e_jk[i] || done !== e_done[i] || busy !== 1'b1 || level !== e_lvl[i]) begin
                bad++; $display("FAIL b2b_cycle%0d got jk=%b done=%b busy=%b level=%0d want jk=%b done=%b busy=1 level=%0d",
                                i, {j, k}, done, busy, level, e_jk[i], e_done[i], e_lvl[i]);
            end
            total++;
            if (exp_q !== e_q[i] || q_in !== e_q[i]) begin
                bad++; $display("FAIL b2b_q%0d got exp_q=%b q_in=%b want %b", i, exp_q, q_in, e_q[i]);
            end
            $display("b2b cycle %0d: jk=%b done=%b exp_q=%b", i, {j, k}, done, exp_q);
        end
        step();
        total++;
        if ({j, k, busy, done, exp_q, err} !== 6'b000000) begin
            bad++; $display("FAIL b2b_end got jk/busy/done/exp_q/err=%b want 000000", {j, k, busy, done, exp_q, err});
        end
    endtask

    task automatic test_toggle();
        logic e_q [4];
        logic e_done [4];
        e_q = '{1'b0, 1'b1, 1'b0, 1'b1};
        e_done = '{1'b0, 1'b0, 1'b0, 1'b1};
        cmd_valid = 1'b1; cmd_op = 2'b11; cmd_len = 4'd3;
        step();
        cmd_valid = 1'b0;
        step();
        for (int i = 0; i < 4; i++) begin
            total++;
            if ({j, k} !== 2'b11 || exp_q !== e_q[i] || done !== e_done[i] || q_in !== e_q[i]) begin
                bad++; $display("FAIL toggle_cycle%0d got jk=%b exp_q=%b q_in=%b done=%b want jk=11 exp_q=%b done=%b",
                                i, {j, k}, exp_q, q_in, done, e_q[i], e_done[i]);
            end
            $display("toggle cycle %0d: jk=%b exp_q=%b", i, {j, k}, exp_q);
            step();
        end
        total++;
        if ({j, k, busy, exp_q} !== 4'b0000) begin
            bad++; $display("FAIL toggle_end got jk/busy/exp_q=%b want 0000", {j, k, busy, exp_q});
        end
    endtask

    task automatic test_fill();
        logic [1:0]       q_op [4];
        logic [LEN_W-1:0] q_len [4];
        logic [1:0]       e_jk [6];
        logic             e_busy [6];
        logic             e_done [6];
        logic             e_q [6];
        bit               found;
        q_op = '{2'b10, 2'b01, 2'b10, 2'b11};
        q_len = '{4'd0, 4'd0, 4'd1, 4'd0};
        e_jk = '{2'b10, 2'b01, 2'b10, 2'b10, 2'b11, 2'b00};
        e_busy = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0};
        e_done = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0};
        e_q = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0};
        cmd_valid = 1'b1; cmd_op = 2'b11; cmd_len = 4'd15;
        step();
        for (int i = 0; i < 4; i++) begin
            cmd_op = q_op[i]; cmd_len = q_len[i];
            step();
        end
        total++;
        if (level !== 3'd4 || cmd_ready !== 1'b0) begin
            bad++; $display("FAIL fill_full got level=%0d ready=%b want level=4 ready=0", level, cmd_ready);
        end
        cmd_op = 2'b00; cmd_len = 4'd5;
        for (int i = 0; i < 3; i++) begin
            step();
            total++;
            if (level !== 3'd4 || cmd_ready !== 1'b0 || {j, k} !== 2'b11) begin
                bad++; $display("FAIL fill_hold%0d got level=%0d ready=%b jk=%b want level=4 ready=0 jk=11", i, level, cmd_ready, {j, k});
            end
        end
        cmd_valid = 1'b0;
        found = 1'b0;
        for (int n = 0; n < 30; n++) begin
            step();
            if (cmd_ready === 1'b1) begin found = 1'b1; break; end
        end
        total++;
        if (!found || level !== 3'd3) begin
            bad++; $display("FAIL fill_ready_return got found=%b level=%0d want found=1 level=3", found, level);
        end
        for (int i = 0; i < 6; i++) begin
            total++;
            if ({j, k} !== e_jk[i] || busy !== e_busy[i] || done !== e_done[i] || exp_q !== e_q[i]) begin
                bad++; $display("FAIL fill_drain%0d got jk=%b busy=%b done=%b exp_q=%b want jk=%b busy=%b done=%b exp_q=%b",
                                i, {j, k}, busy, done, exp_q, e_jk[i], e_busy[i], e_done[i], e_q[i]);
            end
            $display("fill drain %0d: jk=%b busy=%b exp_q=%b level=%0d", i, {j, k}, busy, exp_q, level);
            step();
        end
    endtask

    task automatic test_reset_mid();
        cmd_valid = 1'b1; cmd_op = 2'b10; cmd_len = 4'd7;
        step();
        cmd_op = 2'b11; cmd_len = 4'd2;
        step(); step(); step();
        total++;
        if (level !== 3'd3 || busy !== 1'b1 || exp_q !== 1'b1 || {j, k} !== 2'b10) begin
            bad++; $display("FAIL midrst_pre got level=%0d busy=%b exp_q=%b jk=%b want 3 1 1 10", level, busy, exp_q, {j, k});
        end
        cmd_valid = 1'b0;
        reset = 1'b1;
        step();
        total++;
        if ({j, k, busy, done, exp_q} !== 5'b00000 || level !== 3'd0 || cmd_ready !== 1'b1) begin
            bad++; $display("FAIL midrst_clear got jk/busy/done/exp_q=%b level=%0d ready=%b want 00000 0 1",
                            {j, k, busy, done, exp_q}, level, cmd_ready);
        end
        reset = 1'b0;
        for (int i = 0; i < 10; i++) begin
            step();
            total++;
            if ({j, k, busy} !== 3'b000 || level !== 3'd0) begin
                bad++; $display("FAIL midrst_noreplay%0d got jk/busy=%b level=%0d want 000 0", i, {j, k, busy}, level);
            end
        end
        $display("test_reset_mid: queue discarded");
    endtask

    task automatic test_err();
        logic e_err;
`ifdef JK_SEQ_CHECK_EN
        e_err = 1'b1;
`else
        e_err = 1'b0;
`endif
        total++;
        if (err !== 1'b0) begin bad++; $display("FAIL err_clean got=%b want=0", err); end
        inj = 1'b1;
        step();
        inj = 1'b0;
        total++;
        if (err !== e_err) begin bad++; $display("FAIL err_set got=%b want=%b", err, e_err); end
        step(); step(); step();
        total++;
        if (err !== e_err) begin bad++; $display("FAIL err_sticky got=%b want=%b", err, e_err); end
        reset = 1'b1;
        step();
        reset = 1'b0;
        total++;
        if (err !== 1'b0) begin bad++; $display("FAIL err_reset got=%b want=0", err); end
        $display("test_err: err after injection expected %b", e_err);
    endtask

    initial begin
        test_reset();
        test_back_to_back();
        test_toggle();
        test_fill();
        test_reset_mid();
        test_err();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
